// File: rtl/z_1_rtc_spi_slave_if.sv
// SPI pin bundle between the external master and the z_1 RTC SPI slave front-end.
interface z_1_rtc_spi_slave_if;
  logic sclk_in;
  logic mosi_in;
  logic miso;

  modport slave (
    input  sclk_in,
    input  mosi_in,
    output miso
  );

  modport master (
    output sclk_in,
    output mosi_in,
    input  miso
  );
endinterface

// File: rtl/z_1_rtc_spi_slave.sv
// SPI slave for the z_1 RTC: oversamples sclk/mosi, decodes a command byte and, on the
// read command, snapshots the timestamp and shifts it out MSB first on miso.
module z_1_rtc_spi_slave #(
  parameter logic [7:0]  RdCmd      = 8'h02,
  parameter int unsigned TsWidth    = 64,
  parameter int unsigned IdleCycles = 32
) (
  input  logic               clk,
  input  logic               rst,
  z_1_rtc_spi_slave_if.slave spi,
  input  logic [TsWidth-1:0] rtc_time,
  output logic [7:0]         cmd_byte,
  output logic               cmd_strobe,
  output logic               snap_strobe
);

  localparam int unsigned FrameBits = 8 + TsWidth;
  localparam int unsigned CntW      = $clog2(FrameBits + 1);
  localparam int unsigned IdleW     = $clog2(IdleCycles + 1);

  typedef enum logic [1:0] {StCmd, StData, StDone} state_e;

  state_e               state_q, state_d;
  logic                 sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic                 mosi_s1_q, mosi_s2_q;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [6:0]           cmd_sr_q, cmd_sr_d;
  logic [7:0]           cmd_byte_q, cmd_byte_d;
  logic [TsWidth-1:0]   tx_sr_q, tx_sr_d;
  logic                 miso_q, miso_d;
  logic [IdleW-1:0]     idle_cnt_q, idle_cnt_d;
  logic                 rise, fall, timeout;
  logic [7:0]           rx_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCmd;
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      bit_cnt_q   <= '0;
      cmd_sr_q    <= '0;
      cmd_byte_q  <= '0;
      tx_sr_q     <= '0;
      miso_q      <= 1'b0;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sclk_s1_q   <= spi.sclk_in;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
      mosi_s1_q   <= spi.mosi_in;
      mosi_s2_q   <= mosi_s1_q;
      bit_cnt_q   <= bit_cnt_d;
      cmd_sr_q    <= cmd_sr_d;
      cmd_byte_q  <= cmd_byte_d;
      tx_sr_q     <= tx_sr_d;
      miso_q      <= miso_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  assign rise    = sclk_s2_q & ~sclk_prev_q;
  assign fall    = ~sclk_s2_q & sclk_prev_q;
  // Fires only on the step into IdleCycles; the counter then saturates until sclk goes high.
  assign timeout = ~sclk_s2_q && (idle_cnt_q == IdleW'(IdleCycles - 1));
  assign rx_byte = {cmd_sr_q, mosi_s2_q};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_sr_d    = cmd_sr_q;
    cmd_byte_d  = cmd_byte_q;
    tx_sr_d     = tx_sr_q;
    miso_d      = miso_q;
    idle_cnt_d  = idle_cnt_q;
    cmd_strobe  = 1'b0;
    snap_strobe = 1'b0;

    if (sclk_s2_q) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IdleW'(IdleCycles)) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end

    if (timeout) begin
      state_d   = StCmd;
      bit_cnt_d = '0;
      cmd_sr_d  = '0;
      miso_d    = 1'b0;
    end else begin
      unique case (state_q)
        StCmd: begin
          if (rise) begin
            cmd_sr_d  = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CntW'(7)) begin
              cmd_byte_d = rx_byte;
              cmd_strobe = 1'b1;
              if (rx_byte == RdCmd) begin
                tx_sr_d     = rtc_time;
                snap_strobe = 1'b1;
                state_d     = StData;
              end else begin
                state_d = StDone;
              end
            end
          end
        end
        StData: begin
          if (fall) begin
            miso_d  = tx_sr_q[TsWidth-1];
            tx_sr_d = {tx_sr_q[TsWidth-2:0], 1'b0};
          end
          if (rise) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CntW'(FrameBits - 1)) begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          if (fall) begin
            miso_d = 1'b0;
          end
        end
        default: state_d = StCmd;
      endcase
    end
  end

  assign spi.miso = miso_q;
  assign cmd_byte = cmd_byte_q;

endmodule

// File: tb/tb_z_1_rtc_spi_slave.sv
// Directed bench for z_1_rtc_spi_slave: drives SPI mode-0 frames and checks readout and strobes.
module tb_z_1_rtc_spi_slave;
  logic        clk;
  logic        rst;
  logic [63:0] rtc_time;
  logic [7:0]  cmd_byte;
  logic        cmd_strobe;
  logic        snap_strobe;
  logic        rtc_inc;
  logic        miso_watch;

  int checks   = 0;
  int failures = 0;
  int cmd_cnt  = 0;
  int snap_cnt = 0;
  int miso_bad = 0;
  logic [63:0] snap_val;
  int half = 14;

  z_1_rtc_spi_slave_if spi_if ();

  z_1_rtc_spi_slave dut (
    .clk         (clk),
    .rst         (rst),
    .spi         (spi_if),
    .rtc_time    (rtc_time),
    .cmd_byte    (cmd_byte),
    .cmd_strobe  (cmd_strobe),
    .snap_strobe (snap_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    if (rtc_inc) rtc_time = rtc_time + 64'd1;
  end

  always @(negedge clk) begin
    if (cmd_strobe === 1'b1) cmd_cnt++;
    if (snap_strobe === 1'b1) begin
      snap_cnt++;
      snap_val = rtc_time;
    end
    if (miso_watch && spi_if.miso !== 1'b0) miso_bad++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One mode-0 bit: set mosi in the low phase, sample miso just before the rise.
  task automatic sbit(input logic m, output logic s);
    spi_if.mosi_in = m;
    cycles(half);
    s = spi_if.miso;
    spi_if.sclk_in = 1'b1;
    cycles(half);
    spi_if.sclk_in = 1'b0;
  endtask

  task automatic frame(input logic [7:0] cmd, input int ndata, output logic [63:0] rx);
    logic s;
    rx = '0;
    for (int i = 7; i >= 0; i--) sbit(cmd[i], s);
    for (int i = 0; i < ndata; i++) begin
      sbit(1'b0, s);
      if (i < 64) rx = {rx[62:0], s};
    end
  endtask

  initial begin
    logic [63:0] rx, rx2, exp_snap;
    logic s;
    int c0, s0;
    rst = 1'b1;
    rtc_time = '0;
    rtc_inc = 1'b0;
    miso_watch = 1'b0;
    snap_val = '0;
    spi_if.sclk_in = 1'b0;
    spi_if.mosi_in = 1'b0;
    #1;

    // Reset with sclk toggling
    for (int i = 0; i < 3; i++) begin
      spi_if.sclk_in = ~spi_if.sclk_in;
      cycles(1);
      chk("reset_miso", {63'd0, spi_if.miso}, 64'd0);
    end
    rst = 1'b0;
    spi_if.sclk_in = 1'b0;
    cycles(1);
    chk("reset_cmd_byte", {56'd0, cmd_byte}, 64'd0);
    chk("reset_cmd_strobes", 64'(cmd_cnt), 64'd0);
    chk("reset_snap_strobes", 64'(snap_cnt), 64'd0);
    cycles(43);

    // Basic read
    rtc_time = 64'h0123_4567_89AB_CDEF;
    c0 = cmd_cnt; s0 = snap_cnt;
    frame(8'h02, 64, rx);
    chk("read_data", rx, 64'h0123_4567_89AB_CDEF);
    chk("read_cmd_strobe", 64'(cmd_cnt - c0), 64'd1);
    chk("read_snap_strobe", 64'(snap_cnt - s0), 64'd1);
    chk("read_cmd_byte", {56'd0, cmd_byte}, 64'h02);
    cycles(43);
    chk("read_miso_after", {63'd0, spi_if.miso}, 64'd0);

    // Unknown command
    c0 = cmd_cnt; s0 = snap_cnt;
    miso_watch = 1'b1;
    frame(8'hA5, 64, rx);
    cycles(43);
    miso_watch = 1'b0;
    chk("unk_cmd_byte", {56'd0, cmd_byte}, 64'hA5);
    chk("unk_cmd_strobe", 64'(cmd_cnt - c0), 64'd1);
    chk("unk_snap_strobe", 64'(snap_cnt - s0), 64'd0);
    chk("unk_miso_quiet", 64'(miso_bad), 64'd0);

    // Idle abort after 4 command bits
    c0 = cmd_cnt;
    for (int i = 0; i < 4; i++) sbit(1'b1, s);
    cycles(40);
    rtc_time = 64'hDEAD_BEEF_0BAD_F00D;
    frame(8'h02, 64, rx);
    chk("idle_data", rx, 64'hDEAD_BEEF_0BAD_F00D);
    chk("idle_cmd_byte", {56'd0, cmd_byte}, 64'h02);
    chk("idle_cmd_strobe", 64'(cmd_cnt - c0), 64'd1);
    cycles(43);

    // Snapshot isolation with a moving rtc_time
    s0 = snap_cnt;
    rtc_time = 64'h1111_2222_3333_4444;
    rtc_inc = 1'b1;
    frame(8'h02, 64, rx);
    rtc_inc = 1'b0;
    exp_snap = snap_val;
    chk("iso_snap_strobe", 64'(snap_cnt - s0), 64'd1);
    chk("iso_data", rx, exp_snap);
    chk("iso_not_live", {63'd0, rx == rtc_time}, 64'd0);
    cycles(43);

    // Back-to-back reads with a trailing 73rd clock
    c0 = cmd_cnt;
    rtc_time = 64'hFEDC_BA98_7654_3210;
    frame(8'h02, 65, rx);
    cycles(43);
    chk("b2b_miso_gap", {63'd0, spi_if.miso}, 64'd0);
    rtc_time = 64'h5A5A_0F0F_C3C3_9669;
    frame(8'h02, 65, rx2);
    chk("b2b_data1", rx, 64'hFEDC_BA98_7654_3210);
    chk("b2b_data2", rx2, 64'h5A5A_0F0F_C3C3_9669);
    chk("b2b_cmd_strobes", 64'(cmd_cnt - c0), 64'd2);
    cycles(43);
    chk("b2b_miso_after", {63'd0, spi_if.miso}, 64'd0);

    // Reset in the middle of the data phase
    rtc_time = 64'hFFFF_FFFF_FFFF_FFFF;
    frame(8'h02, 20, rx);
    chk("mid_partial", rx, 64'h0000_0000_000F_FFFF);
    chk("mid_miso_high", {63'd0, spi_if.miso}, 64'd1);
    rst = 1'b1;
    cycles(1);
    chk("mid_rst_miso", {63'd0, spi_if.miso}, 64'd0);
    cycles(1);
    rst = 1'b0;
    cycles(43);
    rtc_time = 64'h0F1E_2D3C_4B5A_6978;
    frame(8'h02, 64, rx);
    chk("post_rst_data", rx, 64'h0F1E_2D3C_4B5A_6978);
    cycles(43);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
